// File: rtl/contador_updown_bcd_param.sv
// Modulo-MOD up/down counter with 2-digit BCD decode and carry/borrow pulses for chaining time fields.
// Latency: a step or load sampled at a clock edge is visible on q at that same edge; digits follow q combinationally.
// Backpressure: none; steps are ignored while en_count is low, and load always wins over a step.
//
// Optional feature macro: CONTADOR_AUTOREPEAT_EN (auto-repeat while a single button is held).
//
// Ports:
//   clk, reset         system clock; synchronous active-high reset
//   en_count           step enable (load is not gated by it)
//   up, down           debounced level requests; each rising edge gives one step
//   load, load_val     synchronous load, clamped to MOD-1
//   q                  binary count, always within 0..MOD-1 after reset
//   digit1, digit0     BCD tens / units of q
//   carry, borrow      one-cycle pulses on up-wrap (MOD-1 -> 0) / down-wrap (0 -> MOD-1)

module contador_updown_bcd_param #(
    parameter int MOD          = 60,
    parameter int N            = 7,
    parameter int PRESCALE     = 12_500_000,
    parameter int REPEAT_DELAY = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_count,
    input  logic         up,
    input  logic         down,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] q,
    output logic [3:0]   digit1,
    output logic [3:0]   digit0,
    output logic         carry,
    output logic         borrow
);

    localparam logic [N-1:0] Q_MAX = N'(MOD - 1);

    // An illegal parameter set elaborates this named marker block, so it is
    // visible in the elaborated hierarchy of any build that gets it wrong.
    if (MOD < 2 || MOD > 100 || (64'd1 << N) < 64'(MOD) ||
        PRESCALE < 1 || REPEAT_DELAY < 1) begin : g_illegal_params
    end

    // ------------------------------------------------------------------
    // Edge detection. The history registers clear in reset, so a button
    // held through reset release reads as a fresh press on the first cycle.
    // ------------------------------------------------------------------
    logic up_d;
    logic down_d;
    logic up_tick;
    logic down_tick;
    logic edge_step;

    assign up_tick   = up & ~up_d;
    assign down_tick = down & ~down_d;
    // Both edges together cancel out: no step at all.
    assign edge_step = en_count & (up_tick ^ down_tick);

    // ------------------------------------------------------------------
    // Auto-repeat
    // ------------------------------------------------------------------
    logic rep_step;
    logic rep_up;

`ifdef CONTADOR_AUTOREPEAT_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int HW = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_DELAY - 1);

    logic [PW-1:0] pre_cnt;
    logic [HW-1:0] hold_cnt;
    logic          holding;

    // Exactly one button held, counting enabled, and no load overriding.
    assign holding = en_count & (up ^ down) & ~load;
    assign rep_up  = up;

    // hold_cnt saturates at HOLD_LAST: once the initial delay has elapsed,
    // every prescaler wrap produces a repeat step.
    assign rep_step = holding & ~edge_step &
                      (pre_cnt == PRE_LAST) & (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (reset || !holding || edge_step) begin
            // The edge step restarts timing so the first repeat lands
            // REPEAT_DELAY*PRESCALE cycles after it.
            pre_cnt  <= '0;
            hold_cnt <= '0;
        end else if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
            if (hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end
`else
    assign rep_step = 1'b0;
    assign rep_up   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Count register: reset > load > step > hold
    // ------------------------------------------------------------------
    logic do_step;
    logic step_up;

    assign do_step = ~load & (edge_step | rep_step);
    assign step_up = edge_step ? up_tick : rep_up;

    always_ff @(posedge clk) begin
        if (reset) begin
            q      <= '0;
            carry  <= 1'b0;
            borrow <= 1'b0;
            up_d   <= 1'b0;
            down_d <= 1'b0;
        end else begin
            up_d   <= up;
            down_d <= down;
            carry  <= 1'b0;
            borrow <= 1'b0;
            if (load) begin
                q <= (load_val > Q_MAX) ? Q_MAX : load_val;
            end else if (do_step) begin
                if (step_up) begin
                    if (q == Q_MAX) begin
                        q     <= '0;
                        carry <= 1'b1;
                    end else begin
                        q <= q + 1'b1;
                    end
                end else begin
                    if (q == '0) begin
                        q      <= Q_MAX;
                        borrow <= 1'b1;
                    end else begin
                        q <= q - 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // BCD decode; q never exceeds 99 because MOD is at most 100.
    // ------------------------------------------------------------------
    logic [31:0] q_ext;

    assign q_ext  = 32'(q);
    assign digit1 = 4'(q_ext / 32'd10);
    assign digit0 = 4'(q_ext % 32'd10);

endmodule

// File: tb/tb_contador_updown_bcd_param.sv
// Scoreboard bench for contador_updown_bcd_param (MOD=60, N=7, PRESCALE=4, REPEAT_DELAY=2).
// Stimulus pushes the model's expected post-edge outputs; a monitor pops and compares every cycle.
// Directed scenarios first, then a randomized phase.

module tb_contador_updown_bcd_param;

    localparam int MOD = 60;
    localparam int N   = 7;
    localparam int P   = 4;
    localparam int RD  = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en_count = 1'b0;
    logic         up = 1'b0;
    logic         down = 1'b0;
    logic         load = 1'b0;
    logic [N-1:0] load_val = '0;
    logic [N-1:0] q;
    logic [3:0]   digit1;
    logic [3:0]   digit0;
    logic         carry;
    logic         borrow;

    always #5 clk = ~clk;

    contador_updown_bcd_param #(
        .MOD(MOD), .N(N), .PRESCALE(P), .REPEAT_DELAY(RD)
    ) dut (
        .clk(clk), .reset(reset), .en_count(en_count), .up(up), .down(down),
        .load(load), .load_val(load_val), .q(q), .digit1(digit1),
        .digit0(digit0), .carry(carry), .borrow(borrow)
    );

    typedef struct packed {
        logic [N-1:0] q;
        logic [3:0]   d1;
        logic [3:0]   d0;
        logic         c;
        logic         b;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

`ifdef CONTADOR_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    // Reference model: plain integers, expressed as "cycles held since the step".
    int m_q, m_age;
    bit m_pu, m_pd, m_c, m_b;

    function automatic void model(input bit r, input bit e, input bit u,
                                  input bit d, input bit l, input int lv);
        bit ut, dt, step, dir;
        step = 0;
        dir  = 0;
        if (r) begin
            m_q = 0; m_age = 0; m_pu = 0; m_pd = 0; m_c = 0; m_b = 0;
            return;
        end
        ut = u && !m_pu;
        dt = d && !m_pd;
        m_c = 0;
        m_b = 0;
        if (l) begin
            m_q   = (lv > MOD - 1) ? MOD - 1 : lv;
            m_age = 0;
        end else begin
            if (e && (ut != dt)) begin
                step = 1; dir = ut; m_age = 0;
            end else if (AUTOREP && e && (u != d)) begin
                m_age++;
                if (m_age >= RD * P && ((m_age - RD * P) % P) == 0) begin
                    step = 1; dir = u;
                end
            end else begin
                m_age = 0;
            end
            if (step) begin
                if (dir) begin
                    if (m_q == MOD - 1) begin m_q = 0; m_c = 1; end
                    else m_q = m_q + 1;
                end else begin
                    if (m_q == 0) begin m_q = MOD - 1; m_b = 1; end
                    else m_q = m_q - 1;
                end
            end
        end
        m_pu = u;
        m_pd = d;
    endfunction

    task automatic cyc(input bit r, input bit e, input bit u, input bit d,
                       input bit l, input int lv);
        exp_t x;
        @(negedge clk);
        reset    = r;
        en_count = e;
        up       = u;
        down     = d;
        load     = l;
        load_val = N'(lv);
        model(r, e, u, d, l, lv);
        x.q  = N'(m_q);
        x.d1 = 4'(m_q / 10);
        x.d0 = 4'(m_q % 10);
        x.c  = m_c;
        x.b  = m_b;
        exp_q.push_back(x);
    endtask

    // Monitor: the DUT presents a fresh output every cycle.
    int cyc_no = 0;
    initial begin : monitor
        exp_t e, g;
        forever begin
            @(posedge clk);
            #2;
            cyc_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {q, digit1, digit0, carry, borrow};
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got q=%0d d=%0d%0d c=%b b=%b, want q=%0d d=%0d%0d c=%b b=%b",
                             cyc_no, g.q, g.d1, g.d0, g.c, g.b, e.q, e.d1, e.d0, e.c, e.b);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit u, d;
        // 1: reset with up held, then one step on release, no more while held.
        repeat (3) cyc(1, 1, 1, 0, 0, 0);
        repeat (5) cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        // 2: load 59, up pulse wraps to 0 with carry.
        cyc(0, 1, 0, 0, 1, 59);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        // 3: down pulse from 0 wraps with borrow; load 75 clamps.
        cyc(0, 1, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 75);
        cyc(0, 1, 0, 0, 0, 0);
        // 4: simultaneous edges cancel; en_count low ignores a pulse.
        cyc(0, 1, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        // 5: load beats a same-cycle up edge.
        cyc(0, 1, 1, 0, 1, 30);
        cyc(0, 1, 0, 0, 0, 0);
        // 6: hold up for 20 cycles from q=10, then release.
        cyc(0, 1, 0, 0, 1, 10);
        repeat (20) cyc(0, 1, 1, 0, 0, 0);
        repeat (10) cyc(0, 1, 0, 0, 0, 0);
        // Held down through a borrow, then reset mid-hold.
        cyc(0, 1, 0, 0, 1, 1);
        repeat (15) cyc(0, 1, 0, 1, 0, 0);
        cyc(1, 1, 0, 1, 0, 0);
        repeat (4) cyc(0, 1, 0, 1, 0, 0);

        // Randomized phase: slowly changing button levels so holds occur.
        u = 0;
        d = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) u = ~u;
            if ($urandom_range(0, 9) == 0) d = ~d;
            cyc($urandom_range(0, 299) == 0,
                $urandom_range(0, 9) != 0,
                u, d,
                $urandom_range(0, 24) == 0,
                int'($urandom_range(0, 127)));
        end
        cyc(0, 1, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #4;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
